// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the IM address and
// buffers fetched words in a QDEPTH-entry queue in front of decode.
// Optional feature macro: FETCH_ADEL_EN (fetch address-error detection + HALT).
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic        d_exc
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  // Reject configurations the wrapping pointers cannot support
  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || IM_WORDS == 0) begin : g_cfg_check
    $error("ifu_fetch_ctrl: QDEPTH must be a power of two >= 2 and IM_WORDS nonzero");
  end

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
`ifdef FETCH_ADEL_EN
    , ST_HALT = 2'd3
`endif
  } state_t;

  state_t         state;
  logic [31:0]    pc;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;
  logic [31:0]    q_instr [QDEPTH];
  logic [31:0]    q_pc    [QDEPTH];

  logic           deq;
  logic           enq;
  logic [CW-1:0]  count_nxt;

`ifdef FETCH_ADEL_EN
  localparam logic [32:0] IM_END = 33'(RESET_PC) + 33'(4 * IM_WORDS);

  logic           q_exc [QDEPTH];
  logic           fetch_bad;

  // Address error: misaligned or outside the IM window
  assign fetch_bad = (pc[1:0] != 2'b00) || (pc < RESET_PC) || ({1'b0, pc} >= IM_END);
  assign d_exc     = q_exc[head];
`else
  assign d_exc     = 1'b0;
`endif

  // Handshake, enqueue qualification and next occupancy
  assign d_valid   = (count != '0);
  assign deq       = d_valid && d_ready;
  assign enq       = ((state == ST_RUN) || ((state == ST_FULL) && deq)) && !redirect;
  assign count_nxt = count + CW'(enq) - CW'(deq);

  // Outputs come straight from the PC and head-entry registers
  assign im_addr = pc;
  assign d_instr = q_instr[head];
  assign d_pc    = q_pc[head];

  // Fetch FSM, PC and queue state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
`ifdef FETCH_ADEL_EN
        q_exc[i]   <= 1'b0;
`endif
      end
    end else if (redirect) begin
      // Flush: queue contents discarded even if decode handshakes this cycle
      state <= ST_RUN;
      pc    <= redirect_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        q_pc[tail] <= pc;
        tail       <= tail + PW'(1);
`ifdef FETCH_ADEL_EN
        q_instr[tail] <= fetch_bad ? 32'h0 : im_rdata;
        q_exc[tail]   <= fetch_bad;
        if (!fetch_bad) begin
          pc <= pc + 32'd4;
        end
`else
        q_instr[tail] <= im_rdata;
        pc            <= pc + 32'd4;
`endif
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      count <= count_nxt;

      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN, ST_FULL: begin
`ifdef FETCH_ADEL_EN
          if (enq && fetch_bad) begin
            state <= ST_HALT;
          end else
`endif
          if (count_nxt == CW'(QDEPTH)) begin
            state <= ST_FULL;
          end else begin
            state <= ST_RUN;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl: expected deliveries are queued as each
// scenario is driven and popped when decode handshakes an entry.
module tb_ifu_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_exc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];

  ifu_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .d_ready     (d_ready),
    .d_valid     (d_valid),
    .d_instr     (d_instr),
    .d_pc        (d_pc),
    .d_exc       (d_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IM model: word k of the image holds 0x1000_0000 + k
  always_comb im_rdata = 32'h1000_0000 + ((im_addr - 32'h0000_3000) >> 2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic exc);
    exp_t e;
    e.pc    = pc;
    e.exc   = exc;
    e.instr = exc ? 32'h0 : 32'h1000_0000 + ((pc - 32'h0000_3000) >> 2);
    exp_q.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges, checks reset outputs, releases into cycle 1 (BOOT)
  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    d_ready  = 1'b0;
    step(2);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_instr", d_instr, 32'd0);
    check("rst_d_pc", d_pc, 32'd0);
    check("rst_d_exc", 32'(d_exc), 32'd0);
    check("rst_im_addr", im_addr, 32'h0000_3000);
    reset = 1'b0;
  endtask

  // Scoreboard: every accepted head entry must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && d_valid && d_ready) begin
      check("sb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", d_pc, e.pc);
        check("sb_instr", d_instr, e.instr);
        check("sb_exc", 32'(d_exc), 32'(e.exc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    d_ready     = 1'b0;

    // Reset release and steady streaming
    do_reset();
    d_ready = 1'b1;
    push_exp(32'h3000, 1'b0);
    push_exp(32'h3004, 1'b0);
    push_exp(32'h3008, 1'b0);
    check("boot_valid", 32'(d_valid), 32'd0);
    check("boot_addr", im_addr, 32'h3000);
    step();
    check("c2_valid", 32'(d_valid), 32'd0);
    check("c2_addr", im_addr, 32'h3000);
    step();
    check("c3_valid", 32'(d_valid), 32'd1);
    check("c3_pc", d_pc, 32'h3000);
    step();
    check("c4_valid", 32'(d_valid), 32'd1);
    check("c4_pc", d_pc, 32'h3004);
    step();
    check("c5_valid", 32'(d_valid), 32'd1);
    check("c5_pc", d_pc, 32'h3008);
    step();
    d_ready = 1'b0;
    check("s1_drain", 32'(exp_q.size()), 32'd0);

    // Decode stall fills the queue, release delivers with no bubble
    do_reset();
    step(2);
    check("st_c3_valid", 32'(d_valid), 32'd1);
    check("st_c3_pc", d_pc, 32'h3000);
    step(2);
    check("st_c5_addr", im_addr, 32'h3008);
    step(2);
    check("st_c7_addr", im_addr, 32'h3008);
    check("st_c7_pc", d_pc, 32'h3000);
    step();
    push_exp(32'h3000, 1'b0);
    push_exp(32'h3004, 1'b0);
    push_exp(32'h3008, 1'b0);
    d_ready = 1'b1;
    step();
    check("st_c9_valid", 32'(d_valid), 32'd1);
    check("st_c9_pc", d_pc, 32'h3004);
    step();
    check("st_c10_valid", 32'(d_valid), 32'd1);
    check("st_c10_pc", d_pc, 32'h3008);
    step();
    d_ready = 1'b0;
    check("s2_drain", 32'(exp_q.size()), 32'd0);

    // Redirect with a simultaneous handshake on a full queue
    do_reset();
    step(4);
    push_exp(32'h3000, 1'b0);
    push_exp(32'h3100, 1'b0);
    push_exp(32'h3104, 1'b0);
    d_ready     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h3100;
    step();
    redirect = 1'b0;
    check("rd_n1_valid", 32'(d_valid), 32'd0);
    check("rd_n1_addr", im_addr, 32'h3100);
    step();
    check("rd_n2_valid", 32'(d_valid), 32'd1);
    check("rd_n2_pc", d_pc, 32'h3100);
    step();
    check("rd_n3_pc", d_pc, 32'h3104);
    step();
    d_ready = 1'b0;
    check("s3_drain", 32'(exp_q.size()), 32'd0);

    // Reset overrides a pending redirect while the queue is full
    do_reset();
    step(4);
    reset       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h3100;
    step();
    reset    = 1'b0;
    redirect = 1'b0;
    check("rr_boot_valid", 32'(d_valid), 32'd0);
    check("rr_boot_pc", d_pc, 32'd0);
    check("rr_boot_addr", im_addr, 32'h3000);
    step();
    check("rr_c2_valid", 32'(d_valid), 32'd0);
    check("rr_c2_addr", im_addr, 32'h3000);
    step();
    check("rr_c3_valid", 32'(d_valid), 32'd1);
    check("rr_c3_pc", d_pc, 32'h3000);
    push_exp(32'h3000, 1'b0);
    d_ready = 1'b1;
    step();
    d_ready = 1'b0;
    check("s4_drain", 32'(exp_q.size()), 32'd0);

`ifdef FETCH_ADEL_EN
    // Misaligned redirect target: one error entry then HALT
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h3002;
    step();
    redirect = 1'b0;
    check("al_addr", im_addr, 32'h3002);
    push_exp(32'h3002, 1'b1);
    step();
    check("al_valid", 32'(d_valid), 32'd1);
    check("al_exc", 32'(d_exc), 32'd1);
    check("al_instr", d_instr, 32'd0);
    d_ready = 1'b1;
    step();
    check("al_halt_valid", 32'(d_valid), 32'd0);
    step();
    check("al_halt_valid2", 32'(d_valid), 32'd0);
    check("al_halt_addr", im_addr, 32'h3002);
    push_exp(32'h3000, 1'b0);
    push_exp(32'h3004, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    step();
    redirect = 1'b0;
    check("al_resume_addr", im_addr, 32'h3000);
    step();
    check("al_resume_valid", 32'(d_valid), 32'd1);
    check("al_resume_pc", d_pc, 32'h3000);
    step(2);
    d_ready = 1'b0;
    check("s5_drain", 32'(exp_q.size()), 32'd0);

    // Sequential fetch crossing the top of IM
    do_reset();
    d_ready     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h6FF8;
    push_exp(32'h6FF8, 1'b0);
    push_exp(32'h6FFC, 1'b0);
    push_exp(32'h7000, 1'b1);
    step();
    redirect = 1'b0;
    step();
    check("top_c3_pc", d_pc, 32'h6FF8);
    step(2);
    check("top_c5_pc", d_pc, 32'h7000);
    check("top_c5_exc", 32'(d_exc), 32'd1);
    step();
    check("top_c6_valid", 32'(d_valid), 32'd0);
    step();
    check("top_c7_valid", 32'(d_valid), 32'd0);
    check("top_c7_addr", im_addr, 32'h7000);
    d_ready = 1'b0;
    check("s6_drain", 32'(exp_q.size()), 32'd0);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction-fetch controller sitting between the PC logic and the combinational instruction memory (word-indexed, base 0x0000_3000). It owns the fetch PC, drives the IM address every cycle, and buffers fetched words in a small queue so the decode stage can stall without re-fetching. It handles redirects from branch/jump/exception logic by flushing the queue and restarting fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset; also the IM base address
- IM_WORDS, 4096, IM capacity in words; the legal range is RESET_PC .. RESET_PC+4*IM_WORDS-1
- QDEPTH, 2, fetch-queue entries; must be a power of two, at least 2
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- im_addr  out  32  byte address presented to IM; equals the fetch PC
- im_rdata  in  32  IM read data, valid in the same cycle as im_addr
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC
- d_ready  in  1  decode accepts the head entry this cycle
- d_valid  out  1  queue head is valid
- d_instr  out  32  head instruction word
- d_pc  out  32  head instruction address
- d_exc  out  1  head entry carries an address-error flag (see Configuration)

## Operation
- FSM states:
  - BOOT: one cycle after reset; no enqueue.
  - RUN: fetching.
  - FULL: count==QDEPTH and no dequeue.
  - HALT: only with FETCH_ADEL_EN.
- Transitions:
  - BOOT→RUN unconditionally.
  - RUN→FULL when an enqueue without a dequeue makes count==QDEPTH.
  - FULL→RUN on a dequeue.
  - RUN→HALT when the fetched PC is illegal.
  - Any state→RUN on redirect; redirect has priority over everything except reset.
- Enqueue condition (same cycle):
  - state is RUN, or state is FULL with a dequeue this cycle;
  - and redirect is 0.
  - On enqueue: write {im_rdata, pc, exc} at the tail, then pc←pc+4 and tail←tail+1 mod QDEPTH.
- Dequeue: d_valid && d_ready, then head←head+1 mod QDEPTH.
- Count: count ← count + enq − deq. Simultaneous enqueue and dequeue while full is legal; count stays at QDEPTH.
- d_valid = (count≠0). d_instr/d_pc/d_exc come straight from the head entry registers with no combinational path from im_rdata.
- Redirect:
  - head, tail and count are cleared; pc←redirect_pc; no enqueue that cycle.
  - A handshake in the same cycle still counts as accepted by decode; queue contents are discarded regardless.
- pc arithmetic: 32-bit wrapping add of 4. No alignment correction.
- Reset values:
  - pc=RESET_PC, head=tail=count=0, state=BOOT.
  - d_valid=0, d_instr=0, d_pc=0, d_exc=0.
  - im_addr=RESET_PC.
  - Queue storage is cleared to 0.
- Reset mid-operation: all in-flight entries are dropped. Reset overrides a simultaneous redirect.

## Timing
- Reset sampled high at edge 0, low afterward:
  - cycle 1 is BOOT;
  - cycle 2 has im_addr=0x3000, enqueued at edge 2;
  - cycle 3 has d_valid=1, d_pc=0x3000.
- Fetch-to-decode latency is 1 cycle. Steady-state throughput is 1 instruction/cycle with d_ready held high.
- Redirect sampled at edge n:
  - cycle n+1 has im_addr=redirect_pc, enqueued at edge n+1;
  - d_valid is 0 during cycle n+1 and 1 at cycle n+2 with d_pc=redirect_pc.
- With d_ready low, fetch stops after QDEPTH enqueues. im_addr holds the next PC until space frees.
- Space freed by a dequeue is usable in the same cycle, so there is no bubble on release.

## Configuration
- FETCH_ADEL_EN defined:
  - The fetched PC is illegal if pc[1:0]≠0, pc<RESET_PC, or pc≥RESET_PC+4*IM_WORDS.
  - An illegal fetch enqueues instr=32'h0 with exc=1, pc unchanged, and the FSM enters HALT.
  - HALT does no further enqueue; the queue still drains.
  - Only redirect or reset leaves HALT.
- FETCH_ADEL_EN undefined: no range or alignment check, the HALT state is absent, and d_exc is tied to 0. An out-of-range PC returns whatever IM produces.

## Test plan
- Reset release, d_ready=1, IM word k = 0x1000_0000+k → d_valid rises in cycle 3; d_pc 0x3000, 0x3004, 0x3008 on consecutive cycles with matching d_instr.
- d_ready=0 for 5 cycles after the first valid → exactly QDEPTH(2) entries held, im_addr frozen at 0x3008. Raising d_ready delivers 0x3000, 0x3004, 0x3008 back-to-back with no gap.
- Redirect to 0x3100 in the same cycle as a handshake with the queue full → next d_valid shows d_pc=0x3100 two cycles later; entries 0x3004/0x3008 are never presented.
- FETCH_ADEL_EN, redirect to 0x3002 → one entry with d_exc=1, d_instr=0, d_pc=0x3002, then d_valid=0 and HALT; redirect to 0x3000 resumes normal fetch.
- FETCH_ADEL_EN, sequential fetch reaching 0x3000+4*4096=0x7000 → 0x6FFC is delivered with d_exc=0, 0x7000 with d_exc=1, then fetch halts.
- Reset asserted for 1 cycle while the queue is full and a redirect is pending → d_valid=0 next cycle, BOOT, then first d_pc=0x3000 (redirect ignored).
